// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_ctrl
// Brief    : Run controller for serial pattern detection with match target,
//            no-match timeout and abort.
// Revision : 1.0
// ============================================================================
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8,
    parameter int TMO_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic [TMO_W-1:0]   cfg_timeout,
    output logic               cfg_err,
    input  logic               start,
    input  logic               abort,
    input  logic               in,
    input  logic               in_valid,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done,
    output logic               timeout_flag
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_TMO  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);

    state_t               r_state;
    logic                 r_cfg_vld;
    logic [MAX_LEN-1:0]   r_pattern;
    logic [LEN_W-1:0]     r_len;
    logic                 r_overlap;
    logic [CNT_W-1:0]     r_target;
    logic [TMO_W-1:0]     r_timeout;
    // Oldest history bit is never compared, so only MAX_LEN-1 bits are kept.
    logic [MAX_LEN-2:0]   r_hist;
    logic [LEN_W-1:0]     r_fill;
    logic [TMO_W-1:0]     r_timer;

    logic [MAX_LEN-1:0]   w_hist_next;
    logic [MAX_LEN-1:0]   w_mask;
    logic                 w_cfg_legal;
    logic                 w_start_ok;
    logic                 w_fill_ok;
    logic                 w_hit;
    logic [LEN_W-1:0]     w_fill_inc;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic                 w_tmo_hit;

    assign cfg_ready   = (r_state == S_IDLE);
    assign w_cfg_legal = (cfg_len != '0) && (cfg_len <= c_max_len);
    // A config accepted in the same cycle as start arms the run with it.
    assign w_start_ok  = start && (r_cfg_vld || (cfg_valid && w_cfg_legal));
    assign w_hist_next = {r_hist, in};
    assign w_fill_ok   = ({1'b0, r_fill} + (LEN_W+1)'(1)) >= {1'b0, r_len};
    assign w_hit       = (r_state == S_RUN) && in_valid && w_fill_ok &&
                         ((w_hist_next & w_mask) == (r_pattern & w_mask));
    assign w_fill_inc  = (r_fill == c_max_len) ? r_fill : r_fill + LEN_W'(1);
    assign w_cnt_inc   = (&match_count) ? match_count : match_count + CNT_W'(1);
    assign w_tmo_hit   = (r_timeout != '0) && (r_timer == r_timeout - TMO_W'(1));

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cfg_vld    <= 1'b0;
            r_pattern    <= '0;
            r_len        <= '0;
            r_overlap    <= 1'b0;
            r_target     <= '0;
            r_timeout    <= '0;
            r_hist       <= '0;
            r_fill       <= '0;
            r_timer      <= '0;
            match        <= 1'b0;
            match_count  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout_flag <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            match   <= 1'b0;
            cfg_err <= 1'b0;
            if (abort) begin
                r_state      <= S_IDLE;
                busy         <= 1'b0;
                done         <= 1'b0;
                timeout_flag <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (cfg_valid) begin
                            if (w_cfg_legal) begin
                                r_pattern <= cfg_pattern;
                                r_len     <= cfg_len;
                                r_overlap <= cfg_overlap;
                                r_target  <= cfg_target;
                                r_timeout <= cfg_timeout;
                                r_cfg_vld <= 1'b1;
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end
                        if (w_start_ok) begin
                            r_state     <= S_RUN;
                            r_hist      <= '0;
                            r_fill      <= '0;
                            r_timer     <= '0;
                            match_count <= '0;
                            busy        <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (in_valid) begin
                            r_hist <= w_hist_next[MAX_LEN-2:0];
                            r_fill <= (w_hit && !r_overlap) ? '0 : w_fill_inc;
                        end
                        if (w_hit) begin
                            match       <= 1'b1;
                            match_count <= w_cnt_inc;
                            r_timer     <= '0;
                            if ((r_target != '0) && (w_cnt_inc == r_target)) begin
                                r_state <= S_DONE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end
                        end else begin
                            r_timer <= r_timer + TMO_W'(1);
                            if (w_tmo_hit) begin
                                r_state      <= S_TMO;
                                busy         <= 1'b0;
                                timeout_flag <= 1'b1;
                            end
                        end
                    end
                    S_DONE, S_TMO: begin
                        if (start) begin
                            r_state      <= S_RUN;
                            r_hist       <= '0;
                            r_fill       <= '0;
                            r_timer      <= '0;
                            match_count  <= '0;
                            busy         <= 1'b1;
                            done         <= 1'b0;
                            timeout_flag <= 1'b0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Run controller for the serial pattern detectors. It accepts a pattern configuration through a valid/ready handshake and arms detection on start. It then screens a qualified serial bit stream, counts matches, and ends the run on a match target, a no-match timeout or an abort. Detection is registered: a match is flagged one clock after the last pattern bit is sampled.

Parameters:
MAX_LEN, 8, maximum pattern length in bits
LEN_W, 4, width of cfg_len; must hold MAX_LEN
CNT_W, 8, width of match target and match counter
TMO_W, 16, width of timeout value and idle timer

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
cfg_valid  input  1  configuration offered
cfg_ready  output  1  high only in IDLE
cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is received first, bit [0] last
cfg_len  input  LEN_W  pattern length; legal range 1..MAX_LEN
cfg_overlap  input  1  1 = overlapping matches allowed
cfg_target  input  CNT_W  matches that end the run; 0 = unlimited
cfg_timeout  input  TMO_W  RUN cycles without a match before timeout; 0 = disabled
cfg_err  output  1  one-cycle pulse when a configuration is rejected
start  input  1  arm or re-arm detection
abort  input  1  return to IDLE
in  input  1  serial data bit
in_valid  input  1  in is sampled only when high
match  output  1  one-cycle pulse per detected match
match_count  output  CNT_W  matches counted in the current run
busy  output  1  high in RUN
done  output  1  high in DONE
timeout_flag  output  1  high in TMO

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, config_valid=0, history=0, fill=0, timer=0.
  - Outputs: match=0, match_count=0, busy=0, done=0, timeout_flag=0, cfg_err=0, cfg_ready=1.
- Every output is registered, except that cfg_ready is decoded from state.
- States are IDLE, RUN, DONE and TMO.
- IDLE, configuration:
  - cfg_valid&cfg_ready with cfg_len in 1..MAX_LEN: latch pattern, len, overlap, target and timeout; set config_valid.
  - Illegal cfg_len (0 or >MAX_LEN): cfg_err=1 for one cycle; previously latched config is kept.
- IDLE, start:
  - start with config_valid=1: next state RUN; history, fill, timer and match_count are cleared.
  - start with config_valid=0: ignored.
  - If cfg handshake and start occur in the same cycle, the new config takes effect first and start uses it.
- RUN, sampling (in_valid=1):
  - history <= {history[MAX_LEN-2:0], in}.
  - fill <= min(fill+1, MAX_LEN).
  - No sampling when in_valid=0.
- RUN, detection:
  - Hit when fill+1 >= len and the new history's low len bits equal pattern[len-1:0].
  - On a hit, at the next edge: match=1, match_count+1 (saturates at all-ones), timer=0.
  - If overlap=0, fill is cleared to 0 after a hit, so the next match needs len fresh bits.
- RUN, timer:
  - Counts +1 each RUN cycle with no hit.
  - If timeout!=0, timer==timeout-1 and no hit this cycle: next state TMO.
  - This gives exactly cfg_timeout hitless cycles before timeout.
- RUN, exits:
  - If target!=0 and a hit makes match_count==target: next state DONE. match=1 and done=1 appear in the same cycle.
  - A hit has priority over timer expiry in the same cycle.
- DONE / TMO:
  - Status held and match_count frozen; in is ignored.
  - start: re-enter RUN with the same config; counters are cleared.
- abort, any state:
  - Next state IDLE; flags cleared; match_count kept; config kept.
  - abort has priority over start, a hit and timeout.
- Reset mid-run: immediate return to the reset values, including config_valid=0.

Test Plan:
- Pattern 0110 (len=4, overlap=1, target=0, timeout=0). Stream 0,1,1,0,1,1,0 (in_valid=1) -> match pulses one cycle after bit4 and after bit7; match_count=2.
- Same stream with overlap=0 -> single match after bit4; match_count=1.
- target=2, pattern 0110 overlap=1, same stream -> done=1 and busy=0 in the same cycle as the second match pulse; further bits ignored; start restarts with match_count=0.
- timeout=5, constant in=1, pattern 0110 -> TMO (timeout_flag=1) entered after exactly 5 RUN cycles.
  - Variant: a hit on cycle 5 instead produces match and the timer restarts.
- cfg_len=0 and cfg_len=9 -> cfg_err pulses and the old config is retained.
  - start before any valid config -> stays IDLE.
- Timing stimuli:
  - in_valid gaps inside the 0110 pattern -> match still detected.
  - abort asserted with start -> IDLE.
  - rst_n low mid-RUN -> all outputs 0 asynchronously and cfg_ready=1.
